button_alu_seq: RTL and testbench

//  Clocked, width-parametrised successor to the two-button AND/ADD lab datapath.
//  Raw pushbuttons are synchronised and edge-detected, and select an operating mode (AND, ADD, SUB, ACC).
//  The result, carry/borrow and mode are registered outputs.

---
 rtl/button_alu_seq_pkg.sv | 10 +
 rtl/button_edge_sync.sv | 26 ++
 rtl/button_alu_seq.sv | 62 ++++++
 tb/tb_button_alu_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/button_alu_seq_pkg.sv
// button_alu_seq_pkg: mode encoding shared by the pushbutton ALU sequencer
package button_alu_seq_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {
    MODE_AND = 2'd0,
    MODE_ADD = 2'd1,
    MODE_SUB = 2'd2,
    MODE_ACC = 2'd3
  } mode_t;
endpackage

// File: rtl/button_edge_sync.sv
// button_edge_sync: synchronises a raw button and emits one pulse per press, ignoring a press held across reset
module button_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] sync, vld;
  logic prev, armed;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      vld   <= '0;
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], raw};
      vld   <= {vld[SYNC_STAGES-2:0], 1'b1};
      prev  <= sync[SYNC_STAGES-1];
      armed <= armed | (vld[SYNC_STAGES-1] & ~sync[SYNC_STAGES-1]);
    end
  end
  assign pulse = armed & sync[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/button_alu_seq.sv
// button_alu_seq: pushbutton-selected AND/ADD/SUB/ACC datapath with registered result, carry and mode
module button_alu_seq
  import button_alu_seq_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              left_pushbutton,
  input  logic              right_pushbutton,
  input  logic              step,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  output logic [WIDTH-1:0]  out,
  output logic              carry,
  output logic [MODE_W-1:0] mode
);
  logic left_press, right_press, entering, res_carry;
  mode_t state, state_next;
  logic [WIDTH-1:0] acc, res_acc, res_out;
  logic [WIDTH:0] add, sub, acc_sum;
  button_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) left_sync (
    .clk, .reset, .raw(left_pushbutton), .pulse(left_press)
  );
  button_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) right_sync (
    .clk, .reset, .raw(right_pushbutton), .pulse(right_press)
  );
  always_ff @(posedge clk) state <= reset ? MODE_AND : state_next;
  always_comb
    state_next = left_press             ? MODE_AND :
                 !right_press           ? state    :
                 state == MODE_AND      ? MODE_ADD :
                 state == MODE_ADD      ? MODE_SUB :
                 state == MODE_SUB      ? MODE_ACC : MODE_ADD;
  always_comb entering = state_next == MODE_ACC && state != MODE_ACC;
  assign mode = state;
  always_comb begin
    add       = {1'b0, A} + {1'b0, B};
    sub       = {1'b0, A} - {1'b0, B};
    acc_sum   = {1'b0, acc} + {1'b0, A};
    res_acc   = (state == MODE_ACC && step) ? acc_sum[WIDTH-1:0] : acc;
    res_out   = state == MODE_AND ? A & B :
                state == MODE_ADD ? add[WIDTH-1:0] :
                state == MODE_SUB ? sub[WIDTH-1:0] : res_acc;
    res_carry = state == MODE_AND ? 1'b0 :
                state == MODE_ADD ? add[WIDTH] :
                state == MODE_SUB ? sub[WIDTH] :
                step              ? acc_sum[WIDTH] : carry;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out   <= '0;
      carry <= 1'b0;
      acc   <= '0;
    end else begin
      out   <= res_out;
      carry <= res_carry & ~entering;
      acc   <= entering ? '0 : res_acc;
    end
  end
endmodule

// File: tb/tb_button_alu_seq.sv
// tb_button_alu_seq: directed, table-driven and randomized checks against a behavioural model
module tb_button_alu_seq;
  logic clk = 1'b0, reset = 1'b1, left_pushbutton = 1'b0, right_pushbutton = 1'b0, step = 1'b0;
  logic [3:0] A = 4'd0, B = 4'd0, out;
  logic carry;
  logic [1:0] mode;
  int vectors = 0, miscompares = 0;

  button_alu_seq #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .left_pushbutton(left_pushbutton),
    .right_pushbutton(right_pushbutton), .step(step), .A(A), .B(B),
    .out(out), .carry(carry), .mode(mode)
  );

  always #5 clk = ~clk;

  // Behavioural model: a press registers three edges after the first high sample,
  // provided the button was seen released (post-reset) at the sample just before.
  bit lh[$], rh[$];
  int since = 0, m_mode = 0, m_out = 0, m_carry = 0, m_acc = 0;
  always @(posedge clk) begin
    int lp, rp, nm, s, a, b;
    lh.push_front(left_pushbutton);
    rh.push_front(right_pushbutton);
    if (lh.size() > 4) begin
      void'(lh.pop_back());
      void'(rh.pop_back());
    end
    a = int'(A);
    b = int'(B);
    if (reset) begin
      since = 0; m_mode = 0; m_out = 0; m_carry = 0; m_acc = 0;
    end else begin
      since++;
      lp = (since > 3 && lh[2] && !lh[3]) ? 1 : 0;
      rp = (since > 3 && rh[2] && !rh[3]) ? 1 : 0;
      nm = lp ? 0 : !rp ? m_mode : (m_mode == 3 ? 1 : m_mode + 1);
      case (m_mode)
        0: begin m_out = a & b; m_carry = 0; end
        1: begin s = a + b; m_out = s % 16; m_carry = s / 16; end
        2: begin m_out = (a - b + 16) % 16; m_carry = (a < b) ? 1 : 0; end
        default: begin
          if (step) begin s = m_acc + a; m_acc = s % 16; m_carry = (s > 15) ? 1 : 0; end
          m_out = m_acc;
        end
      endcase
      if (nm == 3 && m_mode != 3) begin m_acc = 0; m_carry = 0; end
      m_mode = nm;
    end
  end

  typedef struct {
    logic [1:0] m;
    logic [3:0] a, b, o;
    logic c;
  } vec_t;
  vec_t tbl[9];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic press(input bit r);
    if (r) right_pushbutton = 1'b1; else left_pushbutton = 1'b1;
    cyc(5);
    left_pushbutton = 1'b0;
    right_pushbutton = 1'b0;
    cyc(4);
  endtask

  task automatic goto_mode(input logic [1:0] m);
    if (m == 2'd0) press(1'b0);
    for (int i = 0; i < 4 && mode != m; i++) press(1'b1);
    chk("goto mode", int'(mode), int'(m));
  endtask

  initial begin
    tbl[0] = '{2'd0, 4'hF, 4'h3, 4'h3, 1'b0};
    tbl[1] = '{2'd0, 4'hA, 4'h5, 4'h0, 1'b0};
    tbl[2] = '{2'd1, 4'hF, 4'h1, 4'h0, 1'b1};
    tbl[3] = '{2'd1, 4'h7, 4'h8, 4'hF, 1'b0};
    tbl[4] = '{2'd1, 4'h9, 4'h9, 4'h2, 1'b1};
    tbl[5] = '{2'd2, 4'h0, 4'h1, 4'hF, 1'b1};
    tbl[6] = '{2'd2, 4'h5, 4'h5, 4'h0, 1'b0};
    tbl[7] = '{2'd2, 4'h8, 4'h3, 4'h5, 1'b0};
    tbl[8] = '{2'd2, 4'h3, 4'h8, 4'hB, 1'b1};

    A = 4'b1100; B = 4'b1010;
    cyc(2);
    chk("reset mode", int'(mode), 0);
    chk("reset out", int'(out), 0);
    chk("reset carry", int'(carry), 0);
    reset = 1'b0;
    cyc(1);
    chk("and out", int'(out), 8);
    chk("and carry", int'(carry), 0);
    left_pushbutton = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      if (i == 4) left_pushbutton = 1'b0;
      chk("left hold mode", int'(mode), 0);
      chk("left hold out", int'(out), 8);
    end

    right_pushbutton = 1'b1;
    cyc(2);
    chk("right edge2 mode", int'(mode), 0);
    cyc(1);
    chk("right edge3 mode", int'(mode), 1);
    cyc(1);
    chk("add out", int'(out), 6);
    chk("add carry", int'(carry), 1);
    cyc(1);
    right_pushbutton = 1'b0;
    A = 4'b0001; B = 4'b0011;
    cyc(1);
    chk("add2 out", int'(out), 4);
    chk("add2 carry", int'(carry), 0);
    cyc(4);

    press(1'b1);
    chk("sub mode", int'(mode), 2);
    chk("sub out", int'(out), 14);
    chk("sub borrow", int'(carry), 1);
    A = 4'b0011; B = 4'b0001;
    cyc(1);
    chk("sub2 out", int'(out), 2);
    chk("sub2 borrow", int'(carry), 0);

    press(1'b1);
    chk("acc mode", int'(mode), 3);
    chk("acc entry out", int'(out), 0);
    chk("acc entry carry", int'(carry), 0);
    A = 4'b0101; step = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      chk("acc step out", int'(out), (5 * i) % 16);
      chk("acc step carry", int'(carry), i == 4 ? 1 : 0);
    end
    step = 1'b0;
    cyc(2);
    chk("acc hold out", int'(out), 4);
    chk("acc hold carry", int'(carry), 1);

    left_pushbutton = 1'b1; right_pushbutton = 1'b1;
    cyc(5);
    left_pushbutton = 1'b0; right_pushbutton = 1'b0;
    cyc(4);
    chk("both pressed mode", int'(mode), 0);
    right_pushbutton = 1'b1;
    cyc(20);
    chk("right held mode", int'(mode), 1);
    right_pushbutton = 1'b0;
    cyc(4);
    chk("right released mode", int'(mode), 1);
    press(1'b1);
    press(1'b1);
    chk("acc reentry mode", int'(mode), 3);
    chk("acc reentry out", int'(out), 0);

    step = 1'b1;
    cyc(2);
    chk("acc pre-reset out", int'(out), 10);
    reset = 1'b1; right_pushbutton = 1'b1;
    cyc(1);
    chk("mid reset mode", int'(mode), 0);
    chk("mid reset out", int'(out), 0);
    chk("mid reset carry", int'(carry), 0);
    reset = 1'b0; step = 1'b0;
    cyc(10);
    chk("held through reset mode", int'(mode), 0);
    right_pushbutton = 1'b0;
    cyc(4);
    press(1'b1);
    chk("press after reset mode", int'(mode), 1);

    foreach (tbl[i]) begin
      if (mode != tbl[i].m) goto_mode(tbl[i].m);
      A = tbl[i].a; B = tbl[i].b;
      cyc(1);
      chk("table out", int'(out), int'(tbl[i].o));
      chk("table carry", int'(carry), int'(tbl[i].c));
    end

    for (int i = 0; i < 3000; i++) begin
      A = 4'($urandom);
      B = 4'($urandom);
      step = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) left_pushbutton = ~left_pushbutton;
      if ($urandom_range(0, 5) == 0) right_pushbutton = ~right_pushbutton;
      reset = ($urandom_range(0, 299) == 0);
      cyc(1);
      chk("rnd mode", int'(mode), m_mode);
      chk("rnd out", int'(out), m_out);
      chk("rnd carry", int'(carry), m_carry);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
